// File: rtl/h264_intra4x4_modesel.sv
// h264_intra4x4_modesel
// Intra 4x4 luma mode decision and residual generator. Neighbour pixels are
// latched on START. The four source rows are then accepted one per STROBEI.
// While the rows arrive, a three-stage pipeline accumulates the SAD of every
// candidate predictor: row difference, row |diff| sum, and block accumulate.
// The cheapest available mode (after the most-probable-mode bias) is reported
// with a MSTROBEO pulse. The residual and prediction rows are then streamed
// out under READYO back-pressure.
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_start                begin a block (IDLE only); latches neighbours
//   i_top/i_topr/i_left    neighbour pixels p0..p3, p4..p7, l0..l3 (idx 0 in LSBs)
//   i_tvalid/i_trvalid/i_lvalid  neighbour availability
//   i_predmode             most-probable mode (0..8)
//   i_strobe, i_data       source row handshake (row 0 first), pixel x0 in LSBs
//   o_ready                accepting START (IDLE) or rows (LOAD)
//   o_mstrobe              one-cycle pulse, mode result valid
//   o_mode/o_pmode/o_rmode/o_cost  chosen mode, prev flag, rem mode, biased cost
//   o_strobe, i_ready      residual row handshake
//   o_data                 residual (src - pred), BD+1 bit signed per pixel
//   o_base                 prediction row
module h264_intra4x4_modesel #(
  parameter int BIT_DEPTH  = 8,
  parameter int ENABLE_DDL = 1,
  parameter int MODE_BIAS  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [4*BIT_DEPTH-1:0]     i_top,
  input  logic [4*BIT_DEPTH-1:0]     i_topr,
  input  logic [4*BIT_DEPTH-1:0]     i_left,
  input  logic                       i_tvalid,
  input  logic                       i_trvalid,
  input  logic                       i_lvalid,
  input  logic [3:0]                 i_predmode,
  input  logic                       i_strobe,
  input  logic [4*BIT_DEPTH-1:0]     i_data,
  output logic                       o_ready,
  output logic                       o_mstrobe,
  output logic [3:0]                 o_mode,
  output logic                       o_pmode,
  output logic [2:0]                 o_rmode,
  output logic [BIT_DEPTH+4:0]       o_cost,
  output logic                       o_strobe,
  input  logic                       i_ready,
  output logic [4*(BIT_DEPTH+1)-1:0] o_data,
  output logic [4*BIT_DEPTH-1:0]     o_base
);
  localparam int BD = BIT_DEPTH;
  localparam logic [BD+4:0] BIAS = (BD+5)'(MODE_BIAS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC1, S_CALC2, S_DECIDE, S_MODE, S_OUT
  } state_t;

  state_t                r_state, w_next;
  logic [BD-1:0]         r_p [8];
  logic [BD-1:0]         r_l [4];
  logic                  r_tv, r_lv;
  logic [3:0]            r_pm;
  logic [4*BD-1:0]       r_rows [4];
  logic [1:0]            r_row_cnt;
  logic signed [BD:0]    r_diff [4][4];
  logic                  r_v1, r_v2;
  logic [BD+1:0]         r_rowsad [4];
  logic [BD+3:0]         r_sad [4];
  logic [BD+4:0]         r_cost [4];
  logic [3:0]            r_avail;
  logic [1:0]            r_beat;

  logic [BD-1:0]         w_pred [4][4][4];   // [mode][y][x]
  logic [BD-1:0]         w_ddl [7];          // DDL value indexed by x+y
  logic [BD+1:0]         w_sum_t, w_sum_l, w_tmp;
  logic [BD+2:0]         w_sum_tl;
  logic [BD-1:0]         w_dc;
  logic [1:0]            w_sel;
  logic [BD+4:0]         w_sel_cost;
  logic                  w_found, w_pm;
  logic [2:0]            w_rm;
  logic [1:0]            w_ld_row;
  logic [4*(BD+1)-1:0]   w_ld_data;
  logic [4*BD-1:0]       w_ld_base;
  logic                  w_start_acc, w_row_acc;

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_row_acc   = (r_state == S_LOAD) && i_strobe;
  assign o_ready     = (r_state == S_IDLE) || (r_state == S_LOAD);

  function automatic logic [BD-1:0] abs_diff(input logic signed [BD:0] d);
    logic [BD:0] n;
    n = d[BD] ? -d : d;
    return n[BD-1:0];
  endfunction

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_start ? S_LOAD : S_IDLE;
      S_LOAD:   w_next = (i_strobe && r_row_cnt == 2'd3) ? S_CALC1 : S_LOAD;
      S_CALC1:  w_next = S_CALC2;
      S_CALC2:  w_next = S_DECIDE;
      S_DECIDE: w_next = S_MODE;
      S_MODE:   w_next = S_OUT;
      S_OUT:    w_next = (o_strobe && i_ready && r_beat == 2'd3) ? S_IDLE : S_OUT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Neighbour latch; missing top-right pixels replicate p3
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 8; k++) r_p[k] <= '0;
      for (int k = 0; k < 4; k++) r_l[k] <= '0;
      r_tv <= 1'b0;
      r_lv <= 1'b0;
      r_pm <= 4'd0;
    end else if (w_start_acc) begin
      for (int k = 0; k < 4; k++) begin
        r_p[k]   <= i_top[k*BD +: BD];
        r_p[k+4] <= i_trvalid ? i_topr[k*BD +: BD] : i_top[3*BD +: BD];
        r_l[k]   <= i_left[k*BD +: BD];
      end
      r_tv <= i_tvalid;
      r_lv <= i_lvalid;
      r_pm <= i_predmode;
    end
  end

  // Predictor values for all four modes
  always_comb begin
    w_sum_t = '0;
    w_sum_l = '0;
    for (int k = 0; k < 4; k++) begin
      w_sum_t = w_sum_t + {2'b00, r_p[k]};
      w_sum_l = w_sum_l + {2'b00, r_l[k]};
    end
    w_sum_tl = {1'b0, w_sum_t} + {1'b0, w_sum_l} + (BD+3)'(4);
    w_tmp = '0;
    case ({r_tv, r_lv})
      2'b11:   w_dc = w_sum_tl[BD+2:3];
      2'b10:   begin w_tmp = w_sum_t + (BD+2)'(2); w_dc = w_tmp[BD+1:2]; end
      2'b01:   begin w_tmp = w_sum_l + (BD+2)'(2); w_dc = w_tmp[BD+1:2]; end
      default: w_dc = {1'b1, {(BD-1){1'b0}}};
    endcase
    for (int k = 0; k < 6; k++) begin
      w_tmp = {2'b00, r_p[k]} + {1'b0, r_p[k+1], 1'b0} + {2'b00, r_p[k+2]} + (BD+2)'(2);
      w_ddl[k] = w_tmp[BD+1:2];
    end
    // Bottom-right DDL pixel has no p8; the filter folds onto p7
    w_tmp = {2'b00, r_p[6]} + {2'b00, r_p[7]} + {1'b0, r_p[7], 1'b0} + (BD+2)'(2);
    w_ddl[6] = w_tmp[BD+1:2];
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        w_pred[0][y][x] = r_p[x];
        w_pred[1][y][x] = r_l[y];
        w_pred[2][y][x] = w_dc;
        w_pred[3][y][x] = w_ddl[x+y];
      end
    end
  end

  // Row buffer and row counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) r_rows[k] <= '0;
      r_row_cnt <= 2'd0;
    end else if (w_start_acc) begin
      r_row_cnt <= 2'd0;
    end else if (w_row_acc) begin
      r_rows[r_row_cnt] <= i_data;
      r_row_cnt         <= r_row_cnt + 2'd1;
    end
  end

  // SAD pipeline: per-mode row differences, row |diff| sums, block accumulation
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      for (int m = 0; m < 4; m++) begin
        for (int x = 0; x < 4; x++) r_diff[m][x] <= '0;
        r_rowsad[m] <= '0;
        r_sad[m]    <= '0;
      end
    end else begin
      r_v1 <= w_row_acc;
      r_v2 <= r_v1;
      for (int m = 0; m < 4; m++) begin
        if (w_row_acc) begin
          for (int x = 0; x < 4; x++)
            r_diff[m][x] <= $signed({1'b0, i_data[x*BD +: BD]}) - $signed({1'b0, w_pred[m][r_row_cnt][x]});
        end
        if (r_v1)
          r_rowsad[m] <= {2'b00, abs_diff(r_diff[m][0])} + {2'b00, abs_diff(r_diff[m][1])}
                       + {2'b00, abs_diff(r_diff[m][2])} + {2'b00, abs_diff(r_diff[m][3])};
        if (w_start_acc)  r_sad[m] <= '0;
        else if (r_v2)    r_sad[m] <= r_sad[m] + {2'b00, r_rowsad[m]};
      end
    end
  end

  // Biased costs and mode availability
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int m = 0; m < 4; m++) r_cost[m] <= '0;
      r_avail <= 4'd0;
    end else if (r_state == S_DECIDE) begin
      for (int m = 0; m < 4; m++)
        r_cost[m] <= {1'b0, r_sad[m]} + ((4'(m) != r_pm) ? BIAS : '0);
      r_avail <= {r_tv && (ENABLE_DDL != 0), 1'b1, r_lv, r_tv};
    end
  end

  // Minimum-cost selection; ascending scan with strict '<' keeps the lowest mode on ties
  always_comb begin
    w_found    = 1'b0;
    w_sel      = 2'd2;
    w_sel_cost = r_cost[2];
    for (int m = 0; m < 4; m++) begin
      if (r_avail[m] && (!w_found || r_cost[m] < w_sel_cost)) begin
        w_found    = 1'b1;
        w_sel      = 2'(m);
        w_sel_cost = r_cost[m];
      end else begin
        w_found = w_found;
      end
    end
    w_pm = ({2'b00, w_sel} == r_pm);
    if (w_pm)                       w_rm = 3'd0;
    else if ({2'b00, w_sel} < r_pm) w_rm = {1'b0, w_sel};
    else                            w_rm = {1'b0, w_sel - 2'd1};
  end

  // Mode result registers, held until the next block's decision
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mstrobe <= 1'b0;
      o_mode    <= 4'd0;
      o_pmode   <= 1'b0;
      o_rmode   <= 3'd0;
      o_cost    <= '0;
    end else begin
      o_mstrobe <= (r_state == S_MODE);
      if (r_state == S_MODE) begin
        o_mode  <= {2'b00, w_sel};
        o_pmode <= w_pm;
        o_rmode <= w_rm;
        o_cost  <= w_sel_cost;
      end
    end
  end

  // Row to present next: row 0 on the first OUT cycle, otherwise the one after the current beat
  assign w_ld_row = o_strobe ? (r_beat + 2'd1) : 2'd0;

  // Residual and prediction row for w_ld_row under the chosen mode
  always_comb begin
    w_ld_data = '0;
    w_ld_base = '0;
    for (int x = 0; x < 4; x++) begin
      w_ld_base[x*BD +: BD]         = w_pred[o_mode[1:0]][w_ld_row][x];
      w_ld_data[x*(BD+1) +: (BD+1)] = {1'b0, r_rows[w_ld_row][x*BD +: BD]}
                                    - {1'b0, w_pred[o_mode[1:0]][w_ld_row][x]};
    end
  end

  // Output row stream; data holds after the last beat
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_strobe <= 1'b0;
      o_data   <= '0;
      o_base   <= '0;
      r_beat   <= 2'd0;
    end else if (r_state == S_MODE) begin
      r_beat <= 2'd0;
    end else if (r_state == S_OUT) begin
      if (!o_strobe) begin
        o_strobe <= 1'b1;
        o_data   <= w_ld_data;
        o_base   <= w_ld_base;
      end else if (i_ready) begin
        if (r_beat == 2'd3) begin
          o_strobe <= 1'b0;
        end else begin
          r_beat <= r_beat + 2'd1;
          o_data <= w_ld_data;
          o_base <= w_ld_base;
        end
      end
    end
  end
endmodule

// File: tb/tb_h264_intra4x4_modesel.sv
module tb_h264_intra4x4_modesel;
  localparam int BD   = 8;
  localparam int BIAS = 4;

  logic        clk = 1'b0;
  logic        i_rst_n, i_start, i_tvalid, i_trvalid, i_lvalid, i_strobe, i_ready;
  logic [31:0] i_top, i_topr, i_left, i_data;
  logic [3:0]  i_predmode;
  logic        o_ready, o_mstrobe, o_pmode, o_strobe;
  logic [3:0]  o_mode;
  logic [2:0]  o_rmode;
  logic [12:0] o_cost;
  logic [35:0] o_data;
  logic [31:0] o_base;

  always #5 clk = ~clk;

  h264_intra4x4_modesel #(.BIT_DEPTH(BD), .ENABLE_DDL(1), .MODE_BIAS(BIAS)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_top(i_top), .i_topr(i_topr),
    .i_left(i_left), .i_tvalid(i_tvalid), .i_trvalid(i_trvalid), .i_lvalid(i_lvalid),
    .i_predmode(i_predmode), .i_strobe(i_strobe), .i_data(i_data), .o_ready(o_ready),
    .o_mstrobe(o_mstrobe), .o_mode(o_mode), .o_pmode(o_pmode), .o_rmode(o_rmode),
    .o_cost(o_cost), .o_strobe(o_strobe), .i_ready(i_ready), .o_data(o_data), .o_base(o_base)
  );

  int checks = 0;
  int failures = 0;

  // Block description and expected results
  int  top_px[8];
  int  left_px[4];
  int  src[4][4];
  bit  tv, trv, lv;
  int  pm;
  int  exp_mode, exp_cost, exp_pflag, exp_rm;
  logic [35:0] exp_data[4];
  logic [31:0] exp_base[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(a0); b1 = 8'(a1); b2 = 8'(a2); b3 = 8'(a3);
    return {b3, b2, b1, b0};
  endfunction

  // Reference: evaluate every predictor from the formulas, pick the cheapest
  task automatic model();
    int p[8];
    int pr[4][4][4];
    int cost[4];
    bit av[4];
    int st, sl, dc, best, d;
    logic [8:0] r9;
    for (int k = 0; k < 8; k++) p[k] = (k < 4 || trv) ? top_px[k] : top_px[3];
    st = p[0] + p[1] + p[2] + p[3];
    sl = left_px[0] + left_px[1] + left_px[2] + left_px[3];
    if (tv && lv)  dc = (st + sl + 4) / 8;
    else if (tv)   dc = (st + 2) / 4;
    else if (lv)   dc = (sl + 2) / 4;
    else           dc = 128;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        pr[0][y][x] = p[x];
        pr[1][y][x] = left_px[y];
        pr[2][y][x] = dc;
        if (x == 3 && y == 3) pr[3][y][x] = (p[6] + 3 * p[7] + 2) / 4;
        else                  pr[3][y][x] = (p[x+y] + 2 * p[x+y+1] + p[x+y+2] + 2) / 4;
      end
    av[0] = tv; av[1] = lv; av[2] = 1'b1; av[3] = tv;
    best = -1;
    for (int m = 0; m < 4; m++) begin
      cost[m] = (m != pm) ? BIAS : 0;
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) begin
          d = src[y][x] - pr[m][y][x];
          cost[m] += (d < 0) ? -d : d;
        end
      if (av[m] && (best < 0 || cost[m] < cost[best])) best = m;
    end
    exp_mode  = best;
    exp_cost  = cost[best];
    exp_pflag = (best == pm) ? 1 : 0;
    exp_rm    = exp_pflag ? 0 : (best < pm ? best : best - 1);
    for (int y = 0; y < 4; y++) begin
      exp_base[y] = pk(pr[best][y][0], pr[best][y][1], pr[best][y][2], pr[best][y][3]);
      for (int x = 0; x < 4; x++) begin
        r9 = 9'(src[y][x] - pr[best][y][x]);
        exp_data[y][x*9 +: 9] = r9;
      end
    end
  endtask

  // Feed one block, check the decision, drain the residual rows
  task automatic run_block(input string nm, input int stall_beat, input int stall_len, input int rst_beat);
    int beat, stall, cyc;
    bit done;
    model();
    @(negedge clk);
    i_start   = 1'b1;
    i_top     = pk(top_px[0], top_px[1], top_px[2], top_px[3]);
    i_topr    = pk(top_px[4], top_px[5], top_px[6], top_px[7]);
    i_left    = pk(left_px[0], left_px[1], left_px[2], left_px[3]);
    i_tvalid  = tv; i_trvalid = trv; i_lvalid = lv;
    i_predmode = 4'(pm);
    i_strobe  = 1'b1;            // ignored on the START cycle
    i_data    = $urandom;
    @(negedge clk);
    i_start  = 1'b0;
    i_strobe = 1'b0;
    chk({nm, "_ready_load"}, o_ready, 1);
    for (int y = 0; y < 4; y++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_strobe = 1'b0;
        @(negedge clk);
      end
      i_strobe = 1'b1;
      i_data   = pk(src[y][0], src[y][1], src[y][2], src[y][3]);
      @(negedge clk);
    end
    // Row 3 was accepted by the last edge; stray STROBEI/START must be ignored now
    i_strobe = 1'b1;
    i_data   = $urandom;
    i_start  = 1'b1;
    repeat (3) @(negedge clk);
    i_strobe = 1'b0;
    i_start  = 1'b0;
    chk({nm, "_mstrobe_early"}, o_mstrobe, 0);
    @(negedge clk);
    chk({nm, "_mstrobe"}, o_mstrobe, 1);
    chk({nm, "_mode"}, o_mode, exp_mode);
    chk({nm, "_cost"}, o_cost, exp_cost);
    chk({nm, "_pmode"}, o_pmode, exp_pflag);
    chk({nm, "_rmode"}, o_rmode, exp_rm);
    @(negedge clk);
    chk({nm, "_mstrobe_pulse"}, o_mstrobe, 0);
    beat = 0; stall = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      cyc++;
      chk({nm, "_strobe"}, o_strobe, 1);
      chk({nm, "_data"}, o_data, exp_data[beat]);
      chk({nm, "_base"}, o_base, exp_base[beat]);
      chk({nm, "_mode_hold"}, o_mode, exp_mode);
      if (beat == rst_beat) begin
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        chk({nm, "_rst_strobe"}, o_strobe, 0);
        chk({nm, "_rst_ready"}, o_ready, 1);
        chk({nm, "_rst_mode"}, o_mode, 0);
        chk({nm, "_rst_data"}, o_data, 0);
        return;
      end
      if (beat == stall_beat && stall < stall_len) begin
        i_ready = 1'b0;
        stall++;
      end else begin
        i_ready = 1'b1;
      end
      i_start = 1'($urandom_range(0, 1));   // ignored outside IDLE
      @(negedge clk);
      i_start = 1'b0;
      if (i_ready) beat++;
      if (beat == 4) done = 1'b1;
    end
    i_ready = 1'b0;
    chk({nm, "_beats"}, beat, 4);
    chk({nm, "_strobe_end"}, o_strobe, 0);
    chk({nm, "_ready_end"}, o_ready, 1);
    chk({nm, "_data_hold"}, o_data, exp_data[3]);
  endtask

  task automatic set_t1();
    for (int k = 0; k < 8; k++) top_px[k] = 100;
    for (int k = 0; k < 4; k++) left_px[k] = 50;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) src[y][x] = 100;
    tv = 1; trv = 1; lv = 1; pm = 2;
  endtask

  initial begin
    int kind, base, v;
    i_rst_n = 1'b0; i_start = 1'b0; i_strobe = 1'b0; i_ready = 1'b0;
    i_top = '0; i_topr = '0; i_left = '0; i_data = '0;
    i_tvalid = 1'b0; i_trvalid = 1'b0; i_lvalid = 1'b0; i_predmode = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_strobe", o_strobe, 0);
    chk("rst_mstrobe", o_mstrobe, 0);
    chk("rst_cost", o_cost, 0);
    chk("rst_data", o_data, 0);
    i_rst_n = 1'b1;

    // 1: vertical wins, biased cost 4
    set_t1();
    run_block("t1", -1, 0, -1);
    chk("t1_spec_mode", o_mode, 0);
    chk("t1_spec_cost", o_cost, 4);

    // 2: no neighbours, DC=128 which is also the predicted mode
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) src[y][x] = 128;
    tv = 0; lv = 0; pm = 2;
    run_block("t2", -1, 0, -1);
    chk("t2_spec_mode", o_mode, 2);
    chk("t2_spec_pmode", o_pmode, 1);

    // 3: every mode ties, lowest mode wins
    for (int k = 0; k < 8; k++) top_px[k] = 10;
    for (int k = 0; k < 4; k++) left_px[k] = 10;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) src[y][x] = 10;
    tv = 1; trv = 1; lv = 1; pm = 5;
    run_block("t3", -1, 0, -1);
    chk("t3_spec_mode", o_mode, 0);

    // 4: diagonal down-left ramp, then same rows with top-right unavailable
    for (int k = 0; k < 8; k++) top_px[k] = 4 * k;
    for (int k = 0; k < 4; k++) left_px[k] = 0;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) src[y][x] = 4 * (x + y) + 4;
    src[3][3] = 27;
    tv = 1; trv = 1; lv = 0; pm = 3;
    run_block("t4a", -1, 0, -1);
    chk("t4a_spec_mode", o_mode, 3);
    chk("t4a_spec_cost", o_cost, 0);
    trv = 0;
    run_block("t4b", -1, 0, -1);
    chk("t4b_spec_base3", o_base, pk(12, 12, 12, 12));

    // 5: back-pressure at row 1
    set_t1();
    run_block("t5", 1, 3, -1);

    // 6: reset during row 2, then an identical block
    run_block("t6a", -1, 0, 2);
    run_block("t6b", -1, 0, -1);
    chk("t6b_spec_cost", o_cost, 4);

    // Randomized blocks
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 8; k++) top_px[k] = $urandom_range(0, 255);
      for (int k = 0; k < 4; k++) left_px[k] = $urandom_range(0, 255);
      tv = 1'($urandom_range(0, 1)); trv = 1'($urandom_range(0, 1)); lv = 1'($urandom_range(0, 1));
      pm = $urandom_range(0, 8);
      kind = $urandom_range(0, 3);
      base = $urandom_range(0, 255);
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) begin
          case (kind)
            0:       v = $urandom_range(0, 255);
            1:       v = top_px[x] + $urandom_range(0, 6) - 3;
            2:       v = left_px[y] + $urandom_range(0, 6) - 3;
            default: v = base;
          endcase
          src[y][x] = (v < 0) ? 0 : ((v > 255) ? 255 : v);
        end
      run_block("rnd", $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
